// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-phase junction controller.
// Holds the lamp-state enum, clog2 and the per-interval tick limit.
package traffic_pkg;

  // Largest interval that still fits two BCD digits.
  localparam int MAX_TICKS = 99;

  typedef enum logic [1:0] {
    S_ALLRED = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second tick prescaler: counts 0..DIV-1, tick on the last count.
// Ports: clk, rst (sync, high), clr (sync restart), en (hold), tick.
module tl_tick_gen
  import traffic_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Gated by en so a frozen count parked on LAST
  // does not keep reporting ticks.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-phase junction controller: GREEN/YELLOW/ALL-RED per phase, demand skip,
// emergency preempt, BCD countdown. In: CLK RESET DEMAND EMERG_*; out: lamps PHASE DISP_* EMERG_ACT.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_PHASES = 4,
  parameter  int TICK_DIV   = 50000000,
  parameter  int GREEN_S    = 30,
  parameter  int YELLOW_S   = 3,
  parameter  int ALLRED_S   = 2,
  localparam int PW         = clog2(NUM_PHASES)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_PHASES-1:0] DEMAND,
  input  logic                  EMERG_REQ,
  input  logic [PW-1:0]         EMERG_PH,
  output logic [NUM_PHASES-1:0] GREEN,
  output logic [NUM_PHASES-1:0] YELLOW,
  output logic [NUM_PHASES-1:0] RED,
  output logic [PW-1:0]         PHASE,
  output logic [3:0]            DISP_TENS,
  output logic [3:0]            DISP_ONES,
  output logic                  EMERG_ACT
);

  if (NUM_PHASES < 2 || NUM_PHASES > 16) begin : g_bad_phases
    $error("NUM_PHASES must be 2..16");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be >= 2");
  end
  if (GREEN_S < 1 || GREEN_S > MAX_TICKS) begin : g_bad_green
    $error("GREEN_S must be 1..99");
  end
  if (YELLOW_S < 1 || YELLOW_S > MAX_TICKS) begin : g_bad_yellow
    $error("YELLOW_S must be 1..99");
  end
  if (ALLRED_S < 1 || ALLRED_S > MAX_TICKS) begin : g_bad_allred
    $error("ALLRED_S must be 1..99");
  end

  localparam logic [6:0]    T_GREEN  = 7'(GREEN_S);
  localparam logic [6:0]    T_YELLOW = 7'(YELLOW_S);
  localparam logic [6:0]    T_ALLRED = 7'(ALLRED_S);
  localparam logic [PW-1:0] PH_LAST  = PW'(NUM_PHASES - 1);
  localparam logic [PW:0]   PH_COUNT = (PW+1)'(NUM_PHASES);

  state_e        state_q;
  state_e        state_d;
  logic [PW-1:0] cur_q;
  logic [PW-1:0] cur_d;
  logic [6:0]    timer_q;
  logic [6:0]    timer_d;
  logic          emerg_act_q;
  logic          emerg_act_d;

  logic          tick;
  logic          pre_clr;
  logic          pre_en;
  logic          emerg_vld;
  logic          hold;
  logic [PW-1:0] next_ph;
  logic [PW-1:0] cand;
  logic          rr_hit;
  logic [NUM_PHASES-1:0] ph_onehot;

  // Out-of-range preempt targets are ignored entirely.
  assign emerg_vld = EMERG_REQ && ({1'b0, EMERG_PH} < PH_COUNT);

  // Preempt already on the requested green: stop the clock.
  assign hold   = (state_q == S_GREEN) && emerg_vld
                && (EMERG_PH == cur_q);
  assign pre_en = !hold;

  tl_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (CLK),
    .rst  (RESET),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // Round-robin demand search starting after cur; a full lap
  // lands back on cur, so a lone caller is served again.
  always_comb begin
    next_ph = (cur_q == PH_LAST) ? '0 : cur_q + 1'b1;
    rr_hit  = 1'b0;
    cand    = '0;
    if (emerg_vld) begin
      next_ph = EMERG_PH;
    end else begin
      for (int i = 1; i <= NUM_PHASES; i++) begin
        cand = PW'((int'(cur_q) + i) % NUM_PHASES);
        if (!rr_hit && DEMAND[cand]) begin
          rr_hit  = 1'b1;
          next_ph = cand;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    timer_d = timer_q;
    pre_clr = 1'b0;
    unique case (state_q)
      S_GREEN: begin
        if (emerg_vld && (EMERG_PH != cur_q)) begin
          state_d = S_YELLOW;
          timer_d = T_YELLOW;
          pre_clr = 1'b1;
        end else if (!hold && tick) begin
          if (timer_q > 7'd1) begin
            timer_d = timer_q - 7'd1;
          end else begin
            state_d = S_YELLOW;
            timer_d = T_YELLOW;
            pre_clr = 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (tick) begin
          if (timer_q > 7'd1) begin
            timer_d = timer_q - 7'd1;
          end else begin
            state_d = S_ALLRED;
            timer_d = T_ALLRED;
            pre_clr = 1'b1;
          end
        end
      end
      S_ALLRED: begin
        if (tick) begin
          if (timer_q > 7'd1) begin
            timer_d = timer_q - 7'd1;
          end else begin
            state_d = S_GREEN;
            cur_d   = next_ph;
            timer_d = T_GREEN;
            pre_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_ALLRED;
        timer_d = T_ALLRED;
        pre_clr = 1'b1;
      end
    endcase
    // Registered flag: set when the next state is a held preempt green.
    emerg_act_d = emerg_vld && (state_d == S_GREEN)
                && (cur_d == EMERG_PH);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_ALLRED;
      cur_q       <= PH_LAST;
      timer_q     <= T_ALLRED;
      emerg_act_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      timer_q     <= timer_d;
      emerg_act_q <= emerg_act_d;
    end
  end

  assign ph_onehot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << cur_q;

  assign GREEN     = (state_q == S_GREEN)  ? ph_onehot : '0;
  assign YELLOW    = (state_q == S_YELLOW) ? ph_onehot : '0;
  assign RED       = ~(GREEN | YELLOW);
  assign PHASE     = cur_q;
  assign EMERG_ACT = emerg_act_q;
  assign DISP_TENS = 4'(timer_q / 7'd10);
  assign DISP_ONES = 4'(timer_q % 7'd10);

endmodule
